// File: rtl/axis_blender_pkg.sv
// Shared constants and helpers for the blender datapath.
// The alpha weight is a 9-bit fixed-point fraction of ALPHA_FULL.
package axis_blender_pkg;

    localparam int ALPHA_W     = 9;
    localparam int ALPHA_SHIFT = 8;
    localparam logic [ALPHA_W-1:0] ALPHA_FULL = 9'd256;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

    // Weights above full scale saturate so layer 1 is simply opaque.
    function automatic logic [ALPHA_W-1:0] clamp_alpha(input logic [ALPHA_W-1:0] a);
        return (a > ALPHA_FULL) ? ALPHA_FULL : a;
    endfunction

endpackage

// File: rtl/axis_blend_alu.sv
// Combinational weighted mix of two pixels: (p1*a + p0*(FULL-a)) >> SHIFT.
// No pipeline, so callers decide where to register the result.
module axis_blend_alu
    import axis_blender_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8
) (
    input  logic [C_PIXEL_WIDTH-1:0] p0,
    input  logic [C_PIXEL_WIDTH-1:0] p1,
    input  logic [ALPHA_W-1:0]       a,
    output logic [C_PIXEL_WIDTH-1:0] out
);

    localparam int MIX_W = C_PIXEL_WIDTH + ALPHA_W;

    logic [ALPHA_W-1:0] inv_a;
    logic [MIX_W-1:0]   mix;

    // The two weights sum to full scale, so the mix never exceeds max_pixel << SHIFT.
    always_comb begin
        inv_a = ALPHA_FULL - a;
        mix   = ({{ALPHA_W{1'b0}}, p1} * {{C_PIXEL_WIDTH{1'b0}}, a})
              + ({{ALPHA_W{1'b0}}, p0} * {{C_PIXEL_WIDTH{1'b0}}, inv_a});
        out   = C_PIXEL_WIDTH'(mix >> ALPHA_SHIFT);
    end

endmodule

// File: rtl/axis_blend_scanner.sv
// Output raster engine: walks the canvas, pulls layer pixels, blends layer 1 over
// layer 0 and emits an AXI4-Stream video frame (tuser = SOF, tlast = EOL).
module axis_blend_scanner
    import axis_blender_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = 8,
    parameter int C_IMG_WBITS   = 12,
    parameter int C_IMG_HBITS   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [C_IMG_WBITS-1:0]   out_width,
    input  logic [C_IMG_HBITS-1:0]   out_height,
    input  logic [C_PIXEL_WIDTH-1:0] bg_color,
    input  logic [ALPHA_W-1:0]       alpha,
    output logic [C_IMG_WBITS-1:0]   col_idx,
    output logic [C_IMG_HBITS-1:0]   row_idx,
    input  logic                     s0_need,
    input  logic                     s0_valid,
    input  logic [C_PIXEL_WIDTH-1:0] s0_tdata,
    output logic                     s0_next,
    input  logic                     s1_need,
    input  logic                     s1_valid,
    input  logic [C_PIXEL_WIDTH-1:0] s1_tdata,
    output logic                     s1_next,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    scan_state_e              state_q, state_d;
    logic [C_IMG_WBITS-1:0]   col_q, col_d, width_q, width_d;
    logic [C_IMG_HBITS-1:0]   row_q, row_d, height_q, height_d;
    logic [C_PIXEL_WIDTH-1:0] bg_q, bg_d;
    logic [ALPHA_W-1:0]       alpha_q, alpha_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tuser_q, tuser_d;
    logic                     tlast_q, tlast_d;
    logic [C_PIXEL_WIDTH-1:0] tdata_q, tdata_d;

    logic                     avail, oready, adv, start, last_col, last_row;
    logic [C_PIXEL_WIDTH-1:0] p0, p1, blend;

    always_comb begin
        avail    = (!s0_need || s0_valid) && (!s1_need || s1_valid);
        oready   = !tvalid_q || m_axis_tready;
        adv      = (state_q == ST_RUN) && avail && oready;
        start    = (state_q == ST_IDLE) && enable && (out_width != '0) && (out_height != '0);
        last_col = (col_q == width_q - C_IMG_WBITS'(1));
        last_row = (row_q == height_q - C_IMG_HBITS'(1));
        p0       = s0_need ? s0_tdata : bg_q;
        p1       = s1_need ? s1_tdata : bg_q;
    end

    axis_blend_alu #(
        .C_PIXEL_WIDTH(C_PIXEL_WIDTH)
    ) u_alu (
        .p0 (p0),
        .p1 (p1),
        .a  (alpha_q),
        .out(blend)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        width_d  = width_q;
        height_d = height_q;
        bg_d     = bg_q;
        alpha_d  = alpha_q;
        tvalid_d = tvalid_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    col_d    = '0;
                    row_d    = '0;
                    width_d  = out_width;
                    height_d = out_height;
                    bg_d     = bg_color;
                    alpha_d  = clamp_alpha(alpha);
                end
            end
            ST_RUN: begin
                if (adv) begin
                    if (last_col) begin
                        col_d = '0;
                        // Leaving through IDLE guarantees at least one idle cycle between frames.
                        if (last_row) begin
                            row_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            row_d = row_q + C_IMG_HBITS'(1);
                        end
                    end else begin
                        col_d = col_q + C_IMG_WBITS'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (adv) begin
            tvalid_d = 1'b1;
            tdata_d  = blend;
            tuser_d  = (col_q == '0) && (row_q == '0);
            tlast_d  = last_col;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            bg_q     <= '0;
            alpha_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            bg_q     <= bg_d;
            alpha_q  <= alpha_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
        end
    end

    assign s0_next       = adv && s0_need;
    assign s1_next       = adv && s1_need;
    assign col_idx       = col_q;
    assign row_idx       = row_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_blend_scanner.sv
// Randomised frame-level bench: expected beats come from a per-frame raster model
// built from the layer masks/data the bench drives.
module tb_axis_blend_scanner;

    localparam int PW = 8;
    localparam int WB = 12;
    localparam int HB = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [WB-1:0] out_width = '0;
    logic [HB-1:0] out_height = '0;
    logic [PW-1:0] bg_color = '0;
    logic [8:0]    alpha = '0;
    logic [WB-1:0] col_idx;
    logic [HB-1:0] row_idx;
    logic          s0_need = 1'b1, s0_valid = 1'b1, s1_need = 1'b1, s1_valid = 1'b1;
    logic [PW-1:0] s0_tdata = '0, s1_tdata = '0;
    logic          s0_next, s1_next;
    logic          m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tready = 1'b1;

    always #5 clk = ~clk;

    axis_blend_scanner #(
        .C_PIXEL_WIDTH(PW),
        .C_IMG_WBITS  (WB),
        .C_IMG_HBITS  (HB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .out_width    (out_width),
        .out_height   (out_height),
        .bg_color     (bg_color),
        .alpha        (alpha),
        .col_idx      (col_idx),
        .row_idx      (row_idx),
        .s0_need      (s0_need),
        .s0_valid     (s0_valid),
        .s0_tdata     (s0_tdata),
        .s0_next      (s0_next),
        .s1_need      (s1_need),
        .s1_valid     (s1_valid),
        .s1_tdata     (s1_tdata),
        .s1_next      (s1_next),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    endtask

    // Per-frame layer picture: coverage masks and pixel values by (row, col).
    bit         m0 [0:15][0:15];
    bit         m1 [0:15][0:15];
    logic [7:0] d0 [0:15][0:15];
    logic [7:0] d1 [0:15][0:15];
    logic [9:0] exp_q [$];
    int exp_n0, exp_n1, cnt_n0, cnt_n1;
    int vpct = 100;
    int rpct = 100;

    task automatic setup_frame(input int w, input int h, input int a, input int bg,
                               input int d0v, input int d1v, input int s1_cut, input bit rand_need);
        int a_eff, p0, p1, pix;
        a_eff = (a > 256) ? 256 : a;
        exp_q.delete();
        exp_n0 = 0; exp_n1 = 0; cnt_n0 = 0; cnt_n1 = 0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                m0[r][c] = rand_need ? 1'($urandom_range(1)) : 1'b1;
                m1[r][c] = rand_need ? 1'($urandom_range(1)) : (c < s1_cut);
                d0[r][c] = (d0v < 0) ? 8'($urandom) : 8'(d0v);
                d1[r][c] = (d1v < 0) ? 8'($urandom) : 8'(d1v);
            end
        end
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                p0  = m0[r][c] ? int'(d0[r][c]) : bg;
                p1  = m1[r][c] ? int'(d1[r][c]) : bg;
                pix = (p1 * a_eff + p0 * (256 - a_eff)) / 256;
                exp_q.push_back({(c == 0 && r == 0), (c == w - 1), 8'(pix)});
                exp_n0 += int'(m0[r][c]);
                exp_n1 += int'(m1[r][c]);
            end
        end
        out_width  = WB'(w);
        out_height = HB'(h);
        bg_color   = 8'(bg);
        alpha      = 9'(a);
    endtask

    task automatic drive_layers();
        int r, c;
        r = int'(row_idx);
        c = int'(col_idx);
        if (r < 16 && c < 16) begin
            s0_need = m0[r][c];
            s1_need = m1[r][c];
        end else begin
            s0_need = 1'b0;
            s1_need = 1'b0;
        end
        s0_valid      = ($urandom_range(99) < vpct);
        s1_valid      = ($urandom_range(99) < vpct);
        s0_tdata      = (s0_need && r < 16 && c < 16) ? d0[r][c] : 8'($urandom);
        s1_tdata      = (s1_need && r < 16 && c < 16) ? d1[r][c] : 8'($urandom);
        m_axis_tready = ($urandom_range(99) < rpct);
    endtask

    task automatic start_frame(input int w, input int h, input int a, input int bg,
                               input int d0v, input int d1v, input int s1_cut, input bit rand_need);
        @(posedge clk); #1;
        setup_frame(w, h, a, bg, d0v, d1v, s1_cut, rand_need);
        enable = 1'b1;
        drive_layers();
    endtask

    task automatic finish_frame(input string name, input int w, input int h, input int a);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(posedge clk); #1;
            enable = 1'b0;
            // Configuration churn mid-frame must not disturb the running frame.
            out_width  = WB'($urandom);
            out_height = HB'($urandom);
            bg_color   = 8'($urandom);
            alpha      = 9'($urandom);
            drive_layers();
            cyc++;
        end
        check({name, "_beats_left"}, exp_q.size(), 0);
        @(posedge clk); #1;
        drive_layers();
        check({name, "_idle_idx"}, {col_idx, row_idx}, 0);
        check({name, "_s0_next_cnt"}, cnt_n0, exp_n0);
        check({name, "_s1_next_cnt"}, cnt_n1, exp_n1);
        $display("frame %s %0dx%0d alpha=%0d cycles=%0d s0_pulls=%0d s1_pulls=%0d",
                 name, w, h, a, cyc, cnt_n0, cnt_n1);
    endtask

    task automatic run_frame(input string name, input int w, input int h, input int a, input int bg,
                             input int d0v, input int d1v, input int s1_cut, input bit rand_need);
        start_frame(w, h, a, bg, d0v, d1v, s1_cut, rand_need);
        finish_frame(name, w, h, a);
    endtask

    // Output monitor: beat ordering, stall hold, and legality of layer pulls.
    bit         prev_stall = 1'b0;
    logic [10:0] prev_word = '0;
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_word);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, e);
                    end
                end
                if (m_axis_tvalid && !m_axis_tready)
                    check("next_in_stall", {s0_next, s1_next}, 0);
                if (s0_next || s1_next) begin
                    check("next_legal",
                          {(!s0_need || s0_valid) && (!s1_need || s1_valid), s0_next, s1_next},
                          {1'b1, s0_need, s1_need});
                end
                if (s0_next) cnt_n0++;
                if (s1_next) cnt_n1++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_word  = {1'b1, m_axis_tuser, m_axis_tlast, m_axis_tdata};
            end
        end
    end

    initial begin
        bit found;
        #1;
        check("rst_out", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        check("rst_idx", {col_idx, row_idx}, 0);
        check("rst_next", {s0_next, s1_next}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero-sized canvases never leave IDLE.
        out_width = '0; out_height = HB'(3); enable = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("zero_w_idle", {m_axis_tvalid, s0_next, s1_next, col_idx}, 0);
        end
        out_width = WB'(3); out_height = '0;
        repeat (4) begin
            @(posedge clk); #1;
            check("zero_h_idle", {m_axis_tvalid, s0_next, s1_next, row_idx}, 0);
        end
        enable = 1'b0;

        vpct = 100; rpct = 100;
        run_frame("mix128", 4, 2, 128, 0, 100, 200, 4, 1'b0);
        run_frame("alpha300", 4, 2, 300, 0, 10, 77, 4, 1'b0);
        run_frame("alpha0", 4, 2, 0, 0, 10, 77, 4, 1'b0);
        run_frame("s1_bg", 4, 2, 256, 0, 10, 77, 2, 1'b0);
        vpct = 60; rpct = 50;
        run_frame("stalls", 4, 2, 200, 33, -1, -1, 4, 1'b1);

        // Reset in the middle of a frame aborts it; the next frame starts clean.
        vpct = 100; rpct = 100;
        start_frame(4, 2, 128, 0, 100, 200, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            enable = 1'b0;
            drive_layers();
            if (col_idx == 2 && row_idx == 1) found = 1'b1;
        end
        check("reach_2_1", found, 1);
        reset = 1'b1;
        #1;
        check("midrst_out", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        check("midrst_idx_next", {col_idx, row_idx, s0_next, s1_next}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        run_frame("after_rst", 4, 2, 128, 0, 100, 200, 4, 1'b0);

        for (int f = 0; f < 12; f++) begin
            vpct = $urandom_range(100, 50);
            rpct = $urandom_range(100, 40);
            run_frame($sformatf("rand%0d", f), $urandom_range(8, 1), $urandom_range(5, 1),
                      $urandom_range(300, 0), $urandom_range(255, 0), -1, -1, 16, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_blend_scanner.md
# axis_blend_scanner

Output-side raster engine of the blender. Walks the output canvas one pixel at a time and drives `col_idx`/`row_idx` to every upstream layer shifter. It pulls one pixel from each layer whose window covers the position, substitutes a background colour for layers that do not cover it, and alpha-blends layer 1 over layer 0. The result leaves as an AXI4-Stream video frame with `tuser` marking start of frame and `tlast` marking end of line.

## Interface
- `C_PIXEL_WIDTH`, 8, bits per pixel on all data paths
- `C_IMG_WBITS`, 12, width of column index and canvas width
- `C_IMG_HBITS`, 12, width of row index and canvas height
- `clk` in 1: single clock for the whole block
- `reset` in 1: asynchronous, active-high; clears all state
- `enable` in 1: frame start request, sampled in IDLE
- `out_width` in C_IMG_WBITS: canvas width, latched at frame start
- `out_height` in C_IMG_HBITS: canvas height, latched at frame start
- `bg_color` in C_PIXEL_WIDTH: substitute pixel for uncovered layers, latched at frame start
- `alpha` in 9: layer-1 weight, 0..256; values above 256 are clamped to 256; latched at frame start
- `col_idx` out C_IMG_WBITS: current output column, registered
- `row_idx` out C_IMG_HBITS: current output row, registered
- `s0_need`, `s1_need` in 1: layer window covers `col_idx`/`row_idx`
- `s0_valid`, `s1_valid` in 1: layer holds a pixel
- `s0_tdata`, `s1_tdata` in C_PIXEL_WIDTH: layer pixel
- `s0_next`, `s1_next` out 1: consume the layer pixel this cycle
- `m_axis_tvalid` out 1
- `m_axis_tdata` out C_PIXEL_WIDTH
- `m_axis_tuser` out 1: first pixel of frame
- `m_axis_tlast` out 1: last pixel of each line
- `m_axis_tready` in 1

## Operation
- FSM states:
  - IDLE: `enable`=1 with nonzero width and height → latch configuration, clear indices → RUN. Zero width or height stays in IDLE.
  - RUN: traverse positions in raster order.
  - After the advance at (W-1, H-1) → IDLE. Indices return to 0.
- `avail` = (!s0_need | s0_valid) & (!s1_need | s1_valid).
- `oready` = !m_axis_tvalid | m_axis_tready.
- `adv` = RUN & avail & oready.
- `sN_next` = adv & sN_need, combinational.
- Operand selection: `p0` = s0_need ? s0_tdata : bg. `p1` = s1_need ? s1_tdata : bg.
- Blend: `out` = (p1*a + p0*(256-a)) >> 8. Intermediate width is C_PIXEL_WIDTH+9; the result is truncated to C_PIXEL_WIDTH. No overflow is possible.
- On `adv`:
  - Register `out`; set tvalid.
  - tuser = (col==0 & row==0).
  - tlast = (col==W-1).
  - Increment col. At W-1, col wraps to 0 and row increments.
- Output hold: no `adv` and tready=1 → tvalid clears. Data and sideband are held while tvalid & !tready.
- Deasserting `enable` mid-frame has no effect; the frame always completes.
- Configuration changes mid-frame are ignored until the next IDLE→RUN.

## Timing
- Reset values: tvalid, tuser, tlast, tdata = 0; col_idx, row_idx = 0; state IDLE. `sN_next` is 0 because it is gated by RUN.
- IDLE→RUN takes 1 cycle after `enable` is sampled. The first `adv` can occur in the first RUN cycle.
- Latency: `adv` → `m_axis_tvalid` is 1 cycle.
- Throughput is 1 pixel/clock when the layers are valid and tready=1.
- `sN_need` comes from registered indices, so there is no combinational loop through `sN_next`.
- Simultaneous last-pixel `adv` and `enable`=1: go to IDLE first. The new frame starts on the following cycle, which gives a minimum one-cycle gap between frames.
- Reset asserted mid-frame clears everything immediately. Partially delivered frames are not completed.

## Structure
- Shared package `axis_blender_pkg`:
  - alpha width (9)
  - alpha full-scale (256)
  - clamp helper
- Sub-module `axis_blend_alu`: combinational two-operand weighted mix (`p0`, `p1`, `a` → `out`). It is pipeline-free so it can be reused by other blend stages.
- The FSM, counters and output register live in the top module.

## Test plan
- 4x2 canvas, both layers need=1 everywhere, valid=1, alpha=128, s0=100, s1=200 → 8 beats of 150. tuser on beat 0 only; tlast on beats 3 and 7.
- alpha=300 (clamped), s0=10, s1=77 → all beats 77. alpha=0 → all beats 10.
- s1_need=0 for cols 2..3, bg=0, alpha=256 → beats at cols 2..3 are 0. `s1_next` never asserts at those positions.
- s1_valid held low 5 cycles at position (1,0) → no beat and no `s0_next` during the stall. Indices hold at (1,0), then resume.
- Hold tready=0 for 3 cycles mid-line → tdata/tuser/tlast stable, no `sN_next` pulses, no pixel lost or duplicated.
- Assert reset at pixel (2,1) of a 4x2 frame → all outputs 0 and IDLE next edge. A new frame with `enable`=1 starts at (0,0) with tuser=1.
